// File: rtl/sensor_sched_pkg.sv
// rtl/sensor_sched_pkg.sv - shared codes, state encoding and default widths for the sensor poll scheduler
package sensor_sched_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int FRAME_W    = 40;

   typedef enum logic [1:0] {
      OP_NOP        = 2'b00,
      OP_ONESHOT    = 2'b01,
      OP_LOOP_START = 2'b10,
      OP_LOOP_STOP  = 2'b11
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_OK         = 2'b00,
      ST_SENSOR_ERR = 2'b01,
      ST_TIMEOUT    = 2'b10
   } result_status_e;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_PICK   = 3'd1;
   localparam logic [2:0] S_START  = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_OUTPUT = 3'd4;
   localparam logic [2:0] S_GAP    = 3'd5;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin first-set-bit finder starting at a pointer
module rr_pick #(
   parameter int NUM_SENSORS = 32,
   parameter int ADDR_W      = 5
) (
   input  logic [NUM_SENSORS-1:0] mask,
   input  logic [ADDR_W-1:0]      ptr,
   output logic                   found,
   output logic [ADDR_W-1:0]      index
);

   logic [NUM_SENSORS-1:0] rot;
   logic [ADDR_W:0]        sum;

   // Rotate so bit 0 is the pointer position; scan downwards so the lowest offset wins.
   always_comb begin
      rot   = NUM_SENSORS'({mask, mask} >> ptr);
      found = 1'b0;
      index = '0;
      sum   = '0;
      for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
         if (rot[i]) begin
            found = 1'b1;
            sum   = {1'b0, ptr} + (ADDR_W+1)'(i);
            if (sum >= (ADDR_W+1)'(NUM_SENSORS))
               sum = sum - (ADDR_W+1)'(NUM_SENSORS);
            index = sum[ADDR_W-1:0];
         end
      end
   end

endmodule

// File: rtl/sensor_poll_scheduler.sv
// rtl/sensor_poll_scheduler.sv - shares one sensor driver across one-shot and round-robin polled addresses
// Optional error statistics (err_count, stats_clear) with SENSOR_SCHED_STATS_EN.
module sensor_poll_scheduler
   import sensor_sched_pkg::*;
#(
   parameter int NUM_SENSORS    = 32,
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int TIMEOUT_CYCLES = 2_500_000,
   parameter int GAP_CYCLES     = 50_000_000
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [ADDR_W-1:0]      cmd_addr,
   output logic                   sensor_start,
   output logic [ADDR_W-1:0]      sensor_addr,
   input  logic                   sensor_done,
   input  logic                   sensor_error,
   input  logic [FRAME_W-1:0]     sensor_data,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic [ADDR_W-1:0]      result_addr,
   output logic [FRAME_W-1:0]     result_data,
   output logic [1:0]             result_status,
   output logic [NUM_SENSORS-1:0] loop_mask,
`ifdef SENSOR_SCHED_STATS_EN
   output logic [7:0]             err_count,
   input  logic                   stats_clear,
`endif
   output logic                   busy
);

   logic [2:0]             state;
   logic [31:0]            cnt;
   logic                   oneshot_pend;
   logic [ADDR_W-1:0]      oneshot_addr;
   logic [ADDR_W-1:0]      rr_ptr;
   logic                   pick_found;
   logic [ADDR_W-1:0]      pick_idx;
   logic                   cmd_fire;
   logic                   addr_ok;
   logic [NUM_SENSORS-1:0] addr_bit;

   assign cmd_ready = !oneshot_pend;
   assign busy      = (state != S_IDLE);
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign addr_ok   = (32'(cmd_addr) < 32'(NUM_SENSORS));
   assign addr_bit  = {{(NUM_SENSORS-1){1'b0}}, 1'b1} << cmd_addr;

   rr_pick #(
      .NUM_SENSORS (NUM_SENSORS),
      .ADDR_W      (ADDR_W)
   ) u_rr_pick (
      .mask  (loop_mask),
      .ptr   (rr_ptr),
      .found (pick_found),
      .index (pick_idx)
   );

   // Command intake; the one-shot slot is drained by PICK, which cannot coincide with a new one-shot.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         oneshot_pend <= 1'b0;
         oneshot_addr <= '0;
         loop_mask    <= '0;
      end else begin
         if (state == S_PICK && oneshot_pend)
            oneshot_pend <= 1'b0;
         if (cmd_fire && addr_ok) begin
            case (cmd_op)
               OP_ONESHOT: begin
                  oneshot_pend <= 1'b1;
                  oneshot_addr <= cmd_addr;
               end
               OP_LOOP_START: loop_mask <= loop_mask | addr_bit;
               OP_LOOP_STOP:  loop_mask <= loop_mask & ~addr_bit;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         cnt           <= '0;
         rr_ptr        <= '0;
         sensor_start  <= 1'b0;
         sensor_addr   <= '0;
         result_valid  <= 1'b0;
         result_addr   <= '0;
         result_data   <= '0;
         result_status <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (oneshot_pend || (|loop_mask))
                  state <= S_PICK;
            end
            S_PICK: begin
               // Address is presented together with the start pulse so it is stable for its whole life.
               if (oneshot_pend) begin
                  sensor_addr  <= oneshot_addr;
                  sensor_start <= 1'b1;
                  cnt          <= '0;
                  state        <= S_START;
               end else if (pick_found) begin
                  sensor_addr  <= pick_idx;
                  rr_ptr       <= (pick_idx == ADDR_W'(NUM_SENSORS - 1)) ? '0 : pick_idx + 1'b1;
                  sensor_start <= 1'b1;
                  cnt          <= '0;
                  state        <= S_START;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_START: begin
               sensor_start <= 1'b0;
               cnt          <= cnt + 32'd1;
               state        <= S_WAIT;
            end
            S_WAIT: begin
               // The start cycle is counted, so a timeout result lands TIMEOUT_CYCLES after the pulse.
               if (sensor_done) begin
                  result_valid  <= 1'b1;
                  result_addr   <= sensor_addr;
                  result_data   <= sensor_error ? '0 : sensor_data;
                  result_status <= sensor_error ? ST_SENSOR_ERR : ST_OK;
                  state         <= S_OUTPUT;
               end else if (cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                  result_valid  <= 1'b1;
                  result_addr   <= sensor_addr;
                  result_data   <= '0;
                  result_status <= ST_TIMEOUT;
                  state         <= S_OUTPUT;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_OUTPUT: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  cnt          <= '0;
                  state        <= S_GAP;
               end
            end
            S_GAP: begin
               if (cnt == 32'(GAP_CYCLES - 1))
                  state <= S_IDLE;
               else
                  cnt <= cnt + 32'd1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef SENSOR_SCHED_STATS_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         err_count <= '0;
      else if (stats_clear)
         err_count <= '0;
      else if (state == S_OUTPUT && result_valid && result_ready &&
               result_status != ST_OK && err_count != 8'hFF)
         err_count <= err_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// tb/tb_sensor_poll_scheduler.sv - directed self-checking bench for sensor_poll_scheduler
module tb_sensor_poll_scheduler;

   localparam int TMO = 40;
   localparam int GAP = 8;

   logic        clock;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [4:0]  cmd_addr;
   logic        sensor_start;
   logic [4:0]  sensor_addr;
   logic        sensor_done;
   logic        sensor_error;
   logic [39:0] sensor_data;
   logic        result_valid;
   logic        result_ready;
   logic [4:0]  result_addr;
   logic [39:0] result_data;
   logic [1:0]  result_status;
   logic [31:0] loop_mask;
   logic        busy;
`ifdef SENSOR_SCHED_STATS_EN
   logic [7:0]  err_count;
   logic        stats_clear = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   sensor_poll_scheduler #(
      .NUM_SENSORS    (32),
      .ADDR_W         (5),
      .TIMEOUT_CYCLES (TMO),
      .GAP_CYCLES     (GAP)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_addr      (cmd_addr),
      .sensor_start  (sensor_start),
      .sensor_addr   (sensor_addr),
      .sensor_done   (sensor_done),
      .sensor_error  (sensor_error),
      .sensor_data   (sensor_data),
      .result_valid  (result_valid),
      .result_ready  (result_ready),
      .result_addr   (result_addr),
      .result_data   (result_data),
      .result_status (result_status),
      .loop_mask     (loop_mask),
`ifdef SENSOR_SCHED_STATS_EN
      .err_count     (err_count),
      .stats_clear   (stats_clear),
`endif
      .busy          (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [4:0] addr);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      step();
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_addr  = '0;
   endtask

   task automatic wait_start(output logic [4:0] addr);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (sensor_start) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      chk("start_seen", seen, 1'b1);
      addr = sensor_addr;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         if (!busy) break;
         step();
      end
      chk("idle_reached", busy, 1'b0);
   endtask

   task automatic serve(input logic [4:0] exp_addr, input logic [39:0] data,
                        input logic do_stop, input logic [4:0] stop_addr);
      logic [4:0] a;
      wait_start(a);
      chk("start_addr", a, exp_addr);
      step();
      chk("start_pulse_width", sensor_start, 1'b0);
      if (do_stop) send_cmd(2'b11, stop_addr);
      sensor_done = 1'b1;
      sensor_data = data;
      step();
      sensor_done = 1'b0;
      sensor_data = '0;
      chk("result_valid", result_valid, 1'b1);
      chk("result_addr", result_addr, exp_addr);
      chk("result_status", result_status, 2'b00);
      chk("result_data", result_data, data);
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      chk("result_drop", result_valid, 1'b0);
   endtask

   initial begin
      logic [4:0] a;
      int lat;
      reset_n      = 1'b0;
      cmd_valid    = 1'b0;
      cmd_op       = 2'b00;
      cmd_addr     = '0;
      sensor_done  = 1'b0;
      sensor_error = 1'b0;
      sensor_data  = '0;
      result_ready = 1'b0;
      step();
      step();
      chk("rst_sensor_start", sensor_start, 1'b0);
      chk("rst_result_valid", result_valid, 1'b0);
      chk("rst_loop_mask", loop_mask, 32'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      reset_n = 1'b1;
      step();

      // One-shot address 3: start pulse two edges after acceptance.
      send_cmd(2'b01, 5'd3);
      chk("os_cmd_ready_full", cmd_ready, 1'b0);
      chk("os_start_early", sensor_start, 1'b0);
      step();
      chk("os_start_early2", sensor_start, 1'b0);
      step();
      chk("os_start", sensor_start, 1'b1);
      chk("os_start_addr", sensor_addr, 5'd3);
      chk("os_busy", busy, 1'b1);
      step();
      chk("os_start_width", sensor_start, 1'b0);
      chk("os_addr_stable", sensor_addr, 5'd3);
      sensor_done = 1'b1;
      sensor_data = 40'h1A00190033;
      step();
      sensor_done = 1'b0;
      sensor_data = '0;
      chk("os_result_valid", result_valid, 1'b1);
      chk("os_result_addr", result_addr, 5'd3);
      chk("os_result_status", result_status, 2'b00);
      chk("os_result_data", result_data, 40'h1A00190033);
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      chk("os_result_drop", result_valid, 1'b0);
      for (int i = 0; i < GAP - 1; i++) step();
      chk("os_gap_busy", busy, 1'b1);
      step();
      chk("os_gap_done", busy, 1'b0);

      // Round robin over 2, 7, 30; stop 7 while 30 is in flight.
      send_cmd(2'b10, 5'd2);
      send_cmd(2'b10, 5'd7);
      send_cmd(2'b10, 5'd30);
      chk("rr_mask", loop_mask, 32'h4000_0084);
      serve(5'd2,  40'h0000000002, 1'b0, 5'd0);
      serve(5'd7,  40'h0000000007, 1'b0, 5'd0);
      serve(5'd30, 40'h000000001E, 1'b0, 5'd0);
      serve(5'd2,  40'h0000000102, 1'b0, 5'd0);
      serve(5'd7,  40'h0000000107, 1'b0, 5'd0);
      serve(5'd30, 40'h000000011E, 1'b1, 5'd7);
      chk("rr_mask_after_stop", loop_mask, 32'h4000_0004);
      serve(5'd2,  40'h0000000202, 1'b0, 5'd0);
      serve(5'd30, 40'h000000021E, 1'b0, 5'd0);
      send_cmd(2'b11, 5'd2);
      send_cmd(2'b11, 5'd30);
      chk("rr_mask_cleared", loop_mask, 32'h0);
      wait_idle();

      // One-shot 9 issued during GAP has priority over loop address 4.
      send_cmd(2'b10, 5'd4);
      serve(5'd4, 40'hAA00000004, 1'b0, 5'd0);
      send_cmd(2'b01, 5'd9);
      serve(5'd9, 40'hAA00000009, 1'b0, 5'd0);
      serve(5'd4, 40'hAB00000004, 1'b1, 5'd4);
      chk("prio_mask_cleared", loop_mask, 32'h0);
      wait_idle();

      // Timeout on address 5, then backpressure on the result.
      send_cmd(2'b01, 5'd5);
      wait_start(a);
      chk("tmo_start_addr", a, 5'd5);
      lat = 0;
      for (int i = 1; i <= 200; i++) begin
         step();
         if (result_valid) begin
            lat = i;
            break;
         end
      end
      chk("tmo_latency", lat, TMO);
      chk("tmo_status", result_status, 2'b10);
      chk("tmo_data", result_data, 40'h0);
      chk("tmo_addr", result_addr, 5'd5);
      send_cmd(2'b01, 5'd6);
      chk("bp_slot_full", cmd_ready, 1'b0);
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_addr  = 5'd12;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("bp_valid_held", result_valid, 1'b1);
         chk("bp_status_stable", result_status, 2'b10);
         chk("bp_addr_stable", result_addr, 5'd5);
         chk("bp_cmd_ready", cmd_ready, 1'b0);
      end
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_addr  = '0;
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      chk("bp_result_drop", result_valid, 1'b0);

      // Queued one-shot 6 answered with a sensor error.
      wait_start(a);
      chk("err_start_addr", a, 5'd6);
      step();
      sensor_done  = 1'b1;
      sensor_error = 1'b1;
      sensor_data  = 40'hFFFF;
      step();
      sensor_done  = 1'b0;
      sensor_error = 1'b0;
      sensor_data  = '0;
      chk("err_valid", result_valid, 1'b1);
      chk("err_status", result_status, 2'b01);
      chk("err_data", result_data, 40'h0);
      chk("err_addr", result_addr, 5'd6);
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      wait_idle();
      for (int i = 0; i < 10; i++) step();
      chk("rejected_cmd_never_ran", busy, 1'b0);

      // Asynchronous reset while waiting on address 11.
      send_cmd(2'b10, 5'd11);
      wait_start(a);
      chk("rst_start_addr", a, 5'd11);
      step();
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_loop_mask", loop_mask, 32'h0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_sensor_addr", sensor_addr, 5'd0);
      chk("arst_sensor_start", sensor_start, 1'b0);
      chk("arst_result_valid", result_valid, 1'b0);
      chk("arst_result_addr", result_addr, 5'd0);
      chk("arst_result_data", result_data, 40'h0);
      chk("arst_result_status", result_status, 2'b00);
      @(posedge clock);
      #1;
      reset_n     = 1'b1;
      sensor_done = 1'b1;
      sensor_data = 40'h1234;
      step();
      sensor_done = 1'b0;
      sensor_data = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("late_done_no_result", result_valid, 1'b0);
         chk("late_done_idle", busy, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
